// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, one edge pixel per interior window out.
// Latency 1 cycle from accepting edge; single output register, in_ready = !out_valid || out_ready.
module sobel_stream #(
  parameter int DATA_W     = 8,
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int APPROX_LSB = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] thresh,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pixel,
  output logic              out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int MW = DATA_W + 3;
  localparam logic [DATA_W-1:0] PMASK = {DATA_W{1'b1}} << APPROX_LSB;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    mode_q;
  logic [DATA_W-1:0] thresh_q, hold;

  // Line buffers hold the previous two rows; contents are only consumed once row >= 2.
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];

  // Window columns col-2 (index 0) and col-1 (index 1); column col comes straight from input/buffers.
  logic [1:0][DATA_W-1:0] w_top, w_mid, w_bot;

  logic accept, produce, frame_start, is_last, thr_hit;
  logic [DATA_W-1:0] pix, c_top, c_mid, mag_sat, result;
  logic signed [MW-1:0] gx, gy;
  logic [MW-1:0] abs_gx, abs_gy, mag;

  function automatic logic signed [MW-1:0] ext(input logic [DATA_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign pix         = in_pixel & PMASK;
  assign c_top       = lb2[col];
  assign c_mid       = lb1[col];
  assign produce     = (row >= RW'(2)) && (col >= CW'(2));
  assign frame_start = (row == '0) && (col == '0);
  assign is_last     = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));

  // p0 p1 p2 / p3 p4 p5 / p6 p7 p8 with the right-hand column being the current one.
  assign gx = (ext(c_top) + (ext(c_mid) <<< 1) + ext(pix))
            - (ext(w_top[0]) + (ext(w_mid[0]) <<< 1) + ext(w_bot[0]));
  assign gy = (ext(w_top[0]) + (ext(w_top[1]) <<< 1) + ext(c_top))
            - (ext(w_bot[0]) + (ext(w_bot[1]) <<< 1) + ext(pix));

  assign abs_gx  = gx[MW-1] ? MW'(-gx) : MW'(gx);
  assign abs_gy  = gy[MW-1] ? MW'(-gy) : MW'(gy);
  assign mag     = abs_gx + abs_gy;
  assign mag_sat = (|mag[MW-1:DATA_W]) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
  assign thr_hit = mag >= {3'b000, thresh_q};

  // Output index k = col-2, so odd k (reuse the held value) is simply odd col.
  always_comb begin
    result = mag_sat;
    case (mode_q)
      2'd1:    result = thr_hit ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      2'd2:    result = col[0] ? hold : mag_sat;
      default: result = mag_sat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= pix;
      lb2[col] <= lb1[col];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= '0;
      thresh_q  <= '0;
      hold      <= '0;
      w_top     <= '0;
      w_mid     <= '0;
      w_bot     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_pixel <= '0;
    end else begin
      if (accept) begin
        if (col == CW'(IMG_W-1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (frame_start) begin
          mode_q   <= mode;
          thresh_q <= thresh;
        end
        w_top <= {c_top, w_top[1]};
        w_mid <= {c_mid, w_mid[1]};
        w_bot <= {pix,   w_bot[1]};
        if (produce && mode_q == 2'd2 && !col[0])
          hold <= mag_sat;
      end
      if (accept && produce) begin
        out_valid <= 1'b1;
        out_pixel <= result;
        out_last  <= is_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x4 image; a second instance with APPROX_LSB=2 shares the stimulus.
module tb_sobel_stream;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;
  localparam int NOUT = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] thresh, in_pixel;
  logic       in_valid, out_ready;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_pixel;
  logic       in_ready2, out_valid2, out_last2;
  logic [7:0] out_pixel2;

  int checks = 0;
  int errors = 0;
  int img[N];
  int drive_cycles;
  logic [7:0] q_pix[$];
  logic       q_last[$];
  logic [7:0] q2[$];
  int         exp_q[$];

  sobel_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .APPROX_LSB(0)) dut (
    .clk(clk), .rst(rst), .mode(mode), .thresh(thresh),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_last(out_last)
  );

  sobel_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .APPROX_LSB(2)) dut2 (
    .clk(clk), .rst(rst), .mode(mode), .thresh(thresh),
    .in_valid(in_valid), .in_ready(in_ready2), .in_pixel(in_pixel),
    .out_valid(out_valid2), .out_ready(out_ready), .out_pixel(out_pixel2), .out_last(out_last2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        q_pix.push_back(out_pixel);
        q_last.push_back(out_last);
      end
      if (out_valid2 && out_ready) q2.push_back(out_pixel2);
    end
  end

  task automatic clear_q();
    q_pix.delete();
    q_last.delete();
    q2.delete();
  endtask

  // Feed npix pixels of img; thresh switches to th_mid right after pixel (0,0) is taken.
  task automatic drive_frame(input int md, input int th, input int th_mid, input int npix);
    int i = 0;
    int cyc = 0;
    logic acc;
    mode = md[1:0];
    thresh = th[7:0];
    while (i < npix && cyc < 1000) begin
      in_valid = 1'b1;
      in_pixel = img[i][7:0];
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        i++;
        if (i == 1) thresh = th_mid[7:0];
      end
    end
    in_valid = 1'b0;
    drive_cycles = cyc;
    if (cyc >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: accepted %0d of %0d pixels", i, npix);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference stream computed directly from the 2D image.
  task automatic build_expect(input int md, input int th, input int lsb);
    int gx, gy, mag, sat, val, hold;
    int p[3][3];
    exp_q.delete();
    for (int r = 1; r <= H - 2; r++) begin
      hold = 0;
      for (int c = 1; c <= W - 2; c++) begin
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            p[dr][dc] = img[(r - 1 + dr) * W + (c - 1 + dc)] & ~((1 << lsb) - 1);
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[0][0] + 2 * p[0][1] + p[0][2]) - (p[2][0] + 2 * p[2][1] + p[2][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        sat = mag > 255 ? 255 : mag;
        if (md == 1) val = (mag >= th) ? 255 : 0;
        else if (md == 2) begin
          if (((c - 1) % 2) == 0) begin
            val = sat;
            hold = sat;
          end else val = hold;
        end else val = sat;
        exp_q.push_back(val);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'd0; thresh = 8'd0; in_pixel = 8'd0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (out_pixel !== 8'd0) begin errors++; $display("FAIL reset_out_pixel: got %0d want 0", out_pixel); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_flat();
    for (int i = 0; i < N; i++) img[i] = 100;
    clear_q();
    drive_frame(0, 0, 0, N);
    checks++; if (drive_cycles !== N) begin errors++; $display("FAIL flat_throughput: got %0d cycles want %0d", drive_cycles, N); end
    checks++; if (q_pix.size() !== NOUT) begin errors++; $display("FAIL flat_count: got %0d want %0d", q_pix.size(), NOUT); end
    for (int k = 0; k < q_pix.size(); k++) begin
      checks++; if (q_pix[k] !== 8'd0) begin errors++; $display("FAIL flat_pixel[%0d]: got %0d want 0", k, q_pix[k]); end
      checks++; if (q_last[k] !== (k == NOUT - 1)) begin errors++; $display("FAIL flat_last[%0d]: got %b want %b", k, q_last[k], k == NOUT - 1); end
    end
  endtask

  task automatic test_step();
    int expv[6] = '{0, 0, 255, 255, 0, 0};
    for (int i = 0; i < N; i++) img[i] = ((i % W) < 4) ? 0 : 255;
    // mode 3 is reserved and must behave exactly like mode 0
    for (int pass = 0; pass < 2; pass++) begin
      clear_q();
      drive_frame(pass == 0 ? 0 : 3, 0, 0, N);
      checks++; if (q_pix.size() !== NOUT) begin errors++; $display("FAIL step_count mode%0d: got %0d want %0d", pass * 3, q_pix.size(), NOUT); end
      for (int k = 0; k < q_pix.size(); k++) begin
        checks++;
        if (q_pix[k] !== expv[k % 6][7:0]) begin
          errors++; $display("FAIL step_pixel mode%0d [%0d]: got %0d want %0d", pass * 3, k, q_pix[k], expv[k % 6]);
        end
      end
    end
  endtask

  task automatic test_thresh();
    int ths[3] = '{80, 81, 81};
    int mids[3] = '{80, 81, 0};
    int want[3] = '{255, 0, 0};
    for (int i = 0; i < N; i++) img[i] = 10 * (i % W);
    for (int t = 0; t < 3; t++) begin
      clear_q();
      drive_frame(1, ths[t], mids[t], N);
      checks++; if (q_pix.size() !== NOUT) begin errors++; $display("FAIL thresh_count case%0d: got %0d want %0d", t, q_pix.size(), NOUT); end
      for (int k = 0; k < q_pix.size(); k++) begin
        checks++;
        if (q_pix[k] !== want[t][7:0]) begin
          errors++; $display("FAIL thresh_pixel case%0d [%0d]: got %0d want %0d", t, k, q_pix[k], want[t]);
        end
      end
    end
  endtask

  task automatic test_perforate();
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    build_expect(2, 0, 0);
    clear_q();
    drive_frame(2, 0, 0, N);
    checks++; if (q_pix.size() !== NOUT) begin errors++; $display("FAIL perf_count: got %0d want %0d", q_pix.size(), NOUT); end
    for (int k = 0; k < q_pix.size() && k < NOUT; k++) begin
      checks++; if (q_pix[k] !== exp_q[k][7:0]) begin errors++; $display("FAIL perf_pixel[%0d]: got %0d want %0d", k, q_pix[k], exp_q[k]); end
      if ((k % (W - 2)) % 2 == 1) begin
        checks++; if (q_pix[k] !== q_pix[k - 1]) begin errors++; $display("FAIL perf_repeat[%0d]: got %0d want %0d", k, q_pix[k], q_pix[k - 1]); end
      end
    end
  endtask

  task automatic test_approx();
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 3);
    img[W + 3] = 3; img[W + 4] = 0;
    clear_q();
    drive_frame(0, 0, 0, N);
    checks++; if (q2.size() !== NOUT) begin errors++; $display("FAIL approx_count: got %0d want %0d", q2.size(), NOUT); end
    for (int k = 0; k < q2.size(); k++) begin
      checks++; if (q2[k] !== 8'd0) begin errors++; $display("FAIL approx_pixel[%0d]: got %0d want 0", k, q2[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    build_expect(0, 0, 0);
    clear_q();
    fork
      drive_frame(0, 0, 0, N);
      begin
        int n = 0;
        do begin
          @(posedge clk); #1; n++;
        end while (!(out_valid && q_pix.size() >= 3) && n < 200);
        if (n >= 200) begin
          checks++; errors++; $display("FAIL bp_wait: no output after %0d cycles", n);
        end else begin
          out_ready = 1'b0;
          held = out_pixel;
          for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", s, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_pixel !== held) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %0d want v=1 %0d", s, out_valid, out_pixel, held); end
          end
          @(posedge clk); #1;
          out_ready = 1'b1;
        end
      end
    join
    checks++; if (drive_cycles !== N + 5) begin errors++; $display("FAIL bp_cycles: got %0d want %0d", drive_cycles, N + 5); end
    checks++; if (q_pix.size() !== NOUT) begin errors++; $display("FAIL bp_count: got %0d want %0d", q_pix.size(), NOUT); end
    for (int k = 0; k < q_pix.size() && k < NOUT; k++) begin
      checks++; if (q_pix[k] !== exp_q[k][7:0]) begin errors++; $display("FAIL bp_pixel[%0d]: got %0d want %0d", k, q_pix[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    drive_frame(0, 0, 0, 20);
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid[%0d]: got %b want 0", s, out_valid); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    build_expect(0, 0, 0);
    clear_q();
    drive_frame(0, 0, 0, N);
    checks++; if (q_pix.size() !== NOUT) begin errors++; $display("FAIL rst_mid_count: got %0d want %0d", q_pix.size(), NOUT); end
    for (int k = 0; k < q_pix.size() && k < NOUT; k++) begin
      checks++; if (q_pix[k] !== exp_q[k][7:0]) begin errors++; $display("FAIL rst_mid_pixel[%0d]: got %0d want %0d", k, q_pix[k], exp_q[k]); end
      checks++; if (q_last[k] !== (k == NOUT - 1)) begin errors++; $display("FAIL rst_mid_last[%0d]: got %b want %b", k, q_last[k], k == NOUT - 1); end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_step();
    test_thresh();
    test_perforate();
    test_approx();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
